led_ctrl: RTL

Memory-mapped LED and button controller between the CPU data bus and the board's `led0`/`led1`/`led2` and `button` pins. Firmware programs a per-LED mode (off, on, blink, PWM) and a shared tick prescaler. The block then sequences the LED outputs autonomously. It also debounces the button and latches press events for polling.

---
 rtl/led_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/led_ctrl.sv
// led_ctrl: bus-mapped LED sequencer (off/on/blink/PWM) with a debounced, latched button.
// Define LED_CTRL_PWM_EN to build the PWM counter and duty register; otherwise mode 11 acts as mode 01.
//
// state     | meaning
// ST_IDLE   | bus_ready high, waiting for a request
// ST_RESP   | response cycle, rsp_valid high, no new request accepted
module led_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        bus_valid,
   output logic        bus_ready,
   input  logic        bus_wr,
   input  logic [4:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   input  logic        button,
   output logic        led0,
   output logic        led1,
   output logic        led2
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;

   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   logic [0:0]  state_q, state_d;
   logic [31:0] rsp_rdata_q;
   logic [5:0]  ctrl_q;
   logic [15:0] prescale_q;
   logic [7:0]  blink_q;
   logic [15:0] psc_q;
   logic [7:0]  blink_cnt_q;
   logic        phase_q;
   logic        sync1_q, sync2_q;
   logic        level_q;
   logic        sticky_q;
   logic [DBW-1:0] db_cnt_q;
   logic [2:0]  led_q, led_d;
   logic [2:0]  pwm_on;
   logic [31:0] rdata;
   logic [2:0]  reg_sel;
   logic        accept, wr_en, tick, db_done, press;
   logic        wr_ctrl, wr_prescale, wr_blink, wr_btn;
   logic        unused_bits;

   assign bus_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rsp_rdata_q;
   assign accept    = bus_valid & bus_ready;
   assign wr_en     = accept & bus_wr;
   assign reg_sel   = bus_addr[4:2];

   assign wr_ctrl     = wr_en && (reg_sel == 3'd0);
   assign wr_prescale = wr_en && (reg_sel == 3'd1);
   assign wr_blink    = wr_en && (reg_sel == 3'd2);
   assign wr_btn      = wr_en && (reg_sel == 3'd4);

   assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:16]};

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus_valid) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q     <= ST_IDLE;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rsp_rdata_q <= (accept && !bus_wr) ? rdata : 32'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         blink_q    <= '0;
      end else begin
         if (wr_ctrl)     ctrl_q     <= bus_wdata[5:0];
         if (wr_prescale) prescale_q <= bus_wdata[15:0];
         if (wr_blink)    blink_q    <= bus_wdata[7:0];
      end
   end

   // Prescaler: tick while the down-counter sits at zero.
   assign tick = (psc_q == 16'd0);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         psc_q <= '0;
      end else if (wr_prescale) begin
         psc_q <= bus_wdata[15:0];
      end else if (tick) begin
         psc_q <= prescale_q;
      end else begin
         psc_q <= psc_q - 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (wr_blink) begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
      end else if (tick) begin
         if (blink_cnt_q == blink_q) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 8'd1;
         end
      end
   end

`ifdef LED_CTRL_PWM_EN
   logic [23:0] pwm_q;
   logic [7:0]  pwm_cnt_q;
   logic        wr_pwm;

   assign wr_pwm = wr_en && (reg_sel == 3'd3);

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         pwm_q     <= '0;
         pwm_cnt_q <= '0;
      end else begin
         if (wr_pwm) pwm_q <= bus_wdata[23:0];
         if (tick)   pwm_cnt_q <= pwm_cnt_q + 8'd1;
      end
   end

   assign pwm_on = {pwm_cnt_q < pwm_q[23:16], pwm_cnt_q < pwm_q[15:8], pwm_cnt_q < pwm_q[7:0]};
`else
   assign pwm_on = 3'b111;
`endif

   always_comb begin
      rdata = '0;
      case (reg_sel)
         3'd0: rdata = {26'd0, ctrl_q};
         3'd1: rdata = {16'd0, prescale_q};
         3'd2: rdata = {24'd0, blink_q};
`ifdef LED_CTRL_PWM_EN
         3'd3: rdata = {8'd0, pwm_q};
`endif
         3'd4: rdata = {30'd0, sticky_q, level_q};
         default: rdata = '0;
      endcase
   end

   always_comb begin
      led_d = '0;
      for (int i = 0; i < 3; i++) begin
         case (ctrl_q[2*i +: 2])
            2'b00:   led_d[i] = 1'b0;
            2'b01:   led_d[i] = 1'b1;
            2'b10:   led_d[i] = phase_q;
            default: led_d[i] = pwm_on[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) led_q <= '0;
      else         led_q <= led_d;
   end

   assign led0 = led_q[0];
   assign led1 = led_q[1];
   assign led2 = led_q[2];

   // Debounce: the level only follows the synced pin after DEBOUNCE_CYCLES disagreeing samples in a row.
   assign db_done = (sync2_q != level_q) && (db_cnt_q == DB_LAST);
   assign press   = db_done && sync2_q;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q <= button;
         sync2_q <= sync1_q;
         if (db_done) begin
            level_q  <= sync2_q;
            db_cnt_q <= '0;
         end else if (sync2_q != level_q) begin
            db_cnt_q <= db_cnt_q + 1'b1;
         end else begin
            db_cnt_q <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         sticky_q <= 1'b0;
      end else if (press) begin
         sticky_q <= 1'b1;
      end else if (wr_btn && bus_wdata[1]) begin
         sticky_q <= 1'b0;
      end
   end

endmodule
